generation_sequencer: RTL and testbench

Top-level phase sequencer for the three-channel Game of Life engine. It steps every generation through compute, register cycle, display and hold phases. Along the way it issues single-cycle start pulses to the three `cgol_logic` engines and the output controller, and collects their done pulses. It also drives the owner select for the per-channel memory muxes and paces generations with a programmable hold timer.

---
 rtl/cgol_pkg.sv | 11 +
 rtl/done_collector.sv | 20 ++
 rtl/generation_sequencer.sv | 96 +++++++++
 tb/tb_generation_sequencer.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cgol_pkg.sv
// cgol_pkg: shared state, memory-owner and memory-op encodings for the CGOL engine
// Contents: gen_state_t phase enum, OWN_* mux-select codes, MEM_OP_* codes shared with memory_controller.
package cgol_pkg;
   typedef enum logic [2:0] {ST_IDLE, ST_COMPUTE, ST_CYCLE, ST_DISPLAY, ST_HOLD} gen_state_t;
   localparam logic [1:0] OWN_CGOL = 2'd0;
   localparam logic [1:0] OWN_CYCLE = 2'd1;
   localparam logic [1:0] OWN_OUTPUT = 2'd2;
   localparam logic [1:0] OWN_NONE = 2'd3;
   localparam logic [1:0] MEM_OP_CYCLE_REG = 2'b11;
   localparam logic [1:0] MEM_OP_IDLE = 2'b10;
endpackage

// File: rtl/done_collector.sv
// done_collector: sticky per-engine done mask with clear and all-done flag
// Ports: clk, rst (sync, active-high), clr (clear mask), en (accumulate done),
//        done[N-1:0] (engine done pulses), all_done (mask including this cycle's pulses is full).
module done_collector #(
   parameter int N = 3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         en,
   input  logic [N-1:0] done,
   output logic         all_done
);
   logic [N-1:0] mask;
   always_ff @(posedge clk)
      if (rst || clr) mask <= '0;
      else if (en) mask <= mask | done;
   // Folding in the live pulses lets the last done advance the phase on the same edge it is sampled.
   assign all_done = &(mask | done);
endmodule

// File: rtl/generation_sequencer.sv
// generation_sequencer: phase sequencer (compute, register cycle, display, hold) for the 3-channel CGOL engine
// Ports: clk, rst (sync, active-high); i_run (async free-run switch), i_step (one-generation request);
//        o_cgol_start/i_cgol_done (engine handshake), o_out_start/i_out_done (output controller handshake);
//        o_mem_owner (memory mux select), o_cycle_en/o_cycle_addr (register cycle), o_generation, o_busy, o_error.
// Build option: GEN_SEQ_WATCHDOG_EN adds a COMPUTE/DISPLAY timeout that sets sticky o_error and forces IDLE.
module generation_sequencer
   import cgol_pkg::*;
#(
   parameter int NUM_CELLS  = 64,
   parameter int HOLD_TICKS = 12_000_000,
   parameter int WDOG_TICKS = 65_536
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_run,
   input  logic        i_step,
   output logic [2:0]  o_cgol_start,
   input  logic [2:0]  i_cgol_done,
   output logic        o_out_start,
   input  logic        i_out_done,
   output logic [1:0]  o_mem_owner,
   output logic        o_cycle_en,
   output logic [5:0]  o_cycle_addr,
   output logic [15:0] o_generation,
   output logic        o_busy,
   output logic        o_error
);
   localparam int HW = $clog2(HOLD_TICKS + 1);
   gen_state_t state, next;
   logic [1:0] run_q;
   logic [HW-1:0] hold_cnt;
   logic all_done, enter_compute, run_s;
   assign run_s = run_q[1];
   assign enter_compute = next == ST_COMPUTE && state != ST_COMPUTE;
`ifdef GEN_SEQ_WATCHDOG_EN
   logic [16:0] wd_cnt;
   logic wd_fire;
`endif
   done_collector #(.N(3)) u_done (
      .clk(clk),
      .rst(rst),
      .clr(enter_compute),
      .en(state == ST_COMPUTE),
      .done(i_cgol_done),
      .all_done(all_done)
   );
   always_comb begin
      next = state;
      case (state)
         ST_IDLE:    if (run_s || i_step) next = ST_COMPUTE;
         ST_COMPUTE: if (all_done) next = ST_CYCLE;
         ST_CYCLE:   if (o_cycle_addr == 6'(NUM_CELLS - 1)) next = ST_DISPLAY;
         ST_DISPLAY: if (i_out_done) next = ST_HOLD;
         ST_HOLD:    if (hold_cnt == HW'(HOLD_TICKS - 1)) next = run_s ? ST_COMPUTE : ST_IDLE;
         default:    next = ST_IDLE;
      endcase
`ifdef GEN_SEQ_WATCHDOG_EN
      wd_fire = (state == ST_COMPUTE || state == ST_DISPLAY) && next == state && wd_cnt == 17'(WDOG_TICKS - 1);
      if (wd_fire) next = ST_IDLE;
`endif
      o_mem_owner = state == ST_COMPUTE ? OWN_CGOL : state == ST_CYCLE ? OWN_CYCLE :
                    state == ST_DISPLAY ? OWN_OUTPUT : OWN_NONE;
      o_cycle_en = state == ST_CYCLE;
      o_busy = state != ST_IDLE;
   end
   always_ff @(posedge clk)
      if (rst) begin
         state <= ST_IDLE;
         run_q <= '0;
         o_cycle_addr <= '0;
         hold_cnt <= '0;
         o_generation <= '0;
         o_cgol_start <= '0;
         o_out_start <= 1'b0;
      end else begin
         state <= next;
         run_q <= {run_q[0], i_run};
         o_cycle_addr <= (state == ST_CYCLE && next == ST_CYCLE) ? o_cycle_addr + 6'd1 : 6'd0;
         hold_cnt <= (state == ST_HOLD && next == ST_HOLD) ? hold_cnt + HW'(1) : '0;
         o_generation <= (state == ST_DISPLAY && i_out_done) ? o_generation + 16'd1 : o_generation;
         o_cgol_start <= {3{enter_compute}};
         o_out_start <= next == ST_DISPLAY && state != ST_DISPLAY;
      end
`ifdef GEN_SEQ_WATCHDOG_EN
   always_ff @(posedge clk)
      if (rst) begin
         wd_cnt <= '0;
         o_error <= 1'b0;
      end else begin
         wd_cnt <= ((state == ST_COMPUTE || state == ST_DISPLAY) && next == state) ? wd_cnt + 17'd1 : 17'd0;
         if (wd_fire) o_error <= 1'b1;
      end
`else
   assign o_error = 1'b0;
`endif
endmodule

// File: tb/tb_generation_sequencer.sv
// tb_generation_sequencer: self-checking bench for generation_sequencer (table-driven generations plus corner sequences)
module tb_generation_sequencer;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic i_run = 1'b0;
   logic i_step = 1'b0;
   logic [2:0] i_cgol_done = '0;
   logic i_out_done = 1'b0;
   logic [2:0] o_cgol_start;
   logic o_out_start;
   logic [1:0] o_mem_owner;
   logic o_cycle_en;
   logic [5:0] o_cycle_addr;
   logic [15:0] o_generation;
   logic o_busy;
   logic o_error;
   int n_chk = 0;
   int n_fail = 0;
   int n_os = 0;
   int gen_model = 0;
   int q_addr[$];
   int q_gen[$];
   typedef struct {
      int kick;
      int t0, t1, t2;
      int exp_cyc;
      int od;
      bit drop;
      bit exp_idle;
   } vec_t;
   vec_t tbl[5];

   generation_sequencer #(.NUM_CELLS(64), .HOLD_TICKS(10), .WDOG_TICKS(100)) dut (
      .clk(clk),
      .rst(rst),
      .i_run(i_run),
      .i_step(i_step),
      .o_cgol_start(o_cgol_start),
      .i_cgol_done(i_cgol_done),
      .o_out_start(o_out_start),
      .i_out_done(i_out_done),
      .o_mem_owner(o_mem_owner),
      .o_cycle_en(o_cycle_en),
      .o_cycle_addr(o_cycle_addr),
      .o_generation(o_generation),
      .o_busy(o_busy),
      .o_error(o_error)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Advance one clock, sample 1 time unit after the edge, and service the cycle-address scoreboard.
   task automatic tick();
      @(posedge clk);
      #1;
      if (o_cycle_en) begin
         if (q_addr.size() == 0) chk("cycle_en_unexpected", o_cycle_en, 0);
         else chk("cycle_addr", o_cycle_addr, q_addr.pop_front());
      end
      if (o_out_start) n_os++;
   endtask

   task automatic chk_reset();
      chk("rst_cgol_start", o_cgol_start, 0);
      chk("rst_out_start", o_out_start, 0);
      chk("rst_owner", o_mem_owner, 3);
      chk("rst_cycle_en", o_cycle_en, 0);
      chk("rst_cycle_addr", o_cycle_addr, 0);
      chk("rst_generation", o_generation, 0);
      chk("rst_busy", o_busy, 0);
      chk("rst_error", o_error, 0);
   endtask

   task automatic push_addrs();
      for (int a = 0; a < 64; a++) q_addr.push_back(a);
   endtask

   // Drives one generation starting from its first COMPUTE cycle and checks every phase boundary.
   task automatic run_gen(input vec_t v);
      int n, st, os0;
      chk("cgol_start_first", o_cgol_start, 7);
      chk("owner_compute", o_mem_owner, 0);
      st = 1;
      n = 0;
      while (o_mem_owner == 2'd0 && n < 40) begin
         i_cgol_done = {n == v.t2, n == v.t1, n == v.t0};
         if (n == v.exp_cyc - 1) push_addrs();
         tick();
         n++;
         if (o_cgol_start != 3'd0) st++;
      end
      i_cgol_done = '0;
      chk("compute_cycles", n, v.exp_cyc);
      chk("cgol_start_count", st, 1);
      chk("cycle_en_entry", o_cycle_en, 1);
      chk("owner_cycle", o_mem_owner, 1);
      for (int i = 1; i < 64; i++) begin
         i_step = (i == 1);
         tick();
      end
      i_step = 1'b0;
      os0 = n_os;
      tick();
      chk("cycle_queue_empty", q_addr.size(), 0);
      chk("owner_display", o_mem_owner, 2);
      chk("out_start_first", o_out_start, 1);
      chk("cycle_addr_after", o_cycle_addr, 0);
      if (v.drop) i_run = 1'b0;
      for (int i = 0; i < v.od; i++) begin
         i_cgol_done = 3'b111;
         tick();
      end
      i_cgol_done = '0;
      chk("owner_display_wait", o_mem_owner, 2);
      i_out_done = 1'b1;
      gen_model = (gen_model + 1) & 16'hFFFF;
      q_gen.push_back(gen_model);
      tick();
      i_out_done = 1'b0;
      chk("generation", o_generation, q_gen.pop_front());
      chk("out_start_count", n_os - os0, 1);
      chk("owner_hold", o_mem_owner, 3);
      repeat (9) tick();
      chk("hold_last_busy", o_busy, 1);
      tick();
      if (v.exp_idle) begin
         chk("hold_to_idle_busy", o_busy, 0);
         repeat (3) tick();
         chk("idle_stays", o_busy, 0);
      end else begin
         chk("hold_to_compute_owner", o_mem_owner, 0);
      end
   endtask

   initial begin
      int n;
      tbl[0] = '{1, 0, 0, 0, 1, 0, 1'b0, 1'b1};
      tbl[1] = '{2, 5, 9, 7, 10, 3, 1'b0, 1'b0};
      tbl[2] = '{0, 2, 2, 2, 3, 0, 1'b0, 1'b0};
      tbl[3] = '{0, 0, 4, 1, 5, 1, 1'b0, 1'b0};
      tbl[4] = '{0, 8, 0, 3, 9, 5, 1'b1, 1'b1};
      tick();
      tick();
      chk_reset();
      rst = 1'b0;
      i_cgol_done = 3'b111;
      i_out_done = 1'b1;
      tick();
      i_cgol_done = '0;
      i_out_done = 1'b0;
      repeat (3) tick();
      chk("idle_stray_done_busy", o_busy, 0);
      chk("idle_stray_done_owner", o_mem_owner, 3);
      for (int r = 0; r < 5; r++) begin
         if (tbl[r].kick == 1) begin
            i_step = 1'b1;
            tick();
            i_step = 1'b0;
            chk("step_enters_compute", o_busy, 1);
         end else if (tbl[r].kick == 2) begin
            i_run = 1'b1;
            n = 0;
            while (!o_busy && n < 10) begin
               tick();
               n++;
            end
            chk("run_sync_latency", n, 3);
         end
         run_gen(tbl[r]);
      end
      chk("generation_total", o_generation, 5);
      // Reset while the register cycle is at address 30.
      i_run = 1'b1;
      n = 0;
      while (!o_busy && n < 10) begin
         tick();
         n++;
      end
      i_run = 1'b0;
      chk("abort_start", o_cgol_start, 7);
      i_cgol_done = 3'b111;
      push_addrs();
      tick();
      i_cgol_done = '0;
      repeat (30) tick();
      chk("abort_addr_30", o_cycle_addr, 30);
      rst = 1'b1;
      tick();
      chk_reset();
      rst = 1'b0;
      q_addr.delete();
      gen_model = 0;
      i_cgol_done = 3'b111;
      tick();
      i_cgol_done = '0;
      tick();
      chk("abort_stray_busy", o_busy, 0);
      chk("abort_stray_owner", o_mem_owner, 3);
      // Engine 2 never finishes.
      i_run = 1'b1;
      n = 0;
      while (!o_busy && n < 10) begin
         tick();
         n++;
      end
      i_run = 1'b0;
      chk("wdog_enter_compute", o_mem_owner, 0);
      i_cgol_done = 3'b011;
      tick();
      i_cgol_done = '0;
`ifdef GEN_SEQ_WATCHDOG_EN
      n = 1;
      while (o_busy && n < 300) begin
         tick();
         n++;
      end
      chk("wdog_cycles", n, 100);
      chk("wdog_error", o_error, 1);
      chk("wdog_owner", o_mem_owner, 3);
      repeat (5) tick();
      chk("wdog_error_sticky", o_error, 1);
      chk("wdog_stays_idle", o_busy, 0);
`else
      repeat (999) tick();
      chk("nowdog_still_compute", o_mem_owner, 0);
      chk("nowdog_busy", o_busy, 1);
      chk("nowdog_error", o_error, 0);
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
